uartfifo: RTL and testbench

Parametrised buffered UART peripheral for the 6801 system bus, next generation of the current single-byte UART. Adds TX/RX FIFOs of configurable depth, a programmable 16-bit baud divisor with 16x oversampled receive, frame error detection, internal loopback and level-based interrupts. Runs entirely on `sys_clk`, decoded in the `$E6A8` I/O window; `irq` ORs into the CPU IRQ line.

---
 rtl/uartfifo.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uartfifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uartfifo.sv
// uartfifo - buffered UART peripheral for the 6801 system bus.
//
// TX and RX FIFOs of 2^FIFO_AW bytes, programmable 16-bit baud divisor
// (bit time = 16*(DIV+1) clocks), 16x oversampled receiver with framing
// error detection, internal loopback and level-based interrupts.
//
// Ports:
//   clk  - system clock (sys_clk)
//   rst  - asynchronous reset, active low
//   AD   - register select (0 DATA, 1 STATUS, 2 CONTROL, 3 DIVL, 4 DIVH,
//          5 RXLVL, 6 TXLVL, 7 reserved)
//   DI   - CPU write data
//   DO   - CPU read data, combinational from AD
//   rw   - 1 = read, 0 = write
//   cs   - chip select (VMA-qualified)
//   irq  - level interrupt, active high
//   rxd  - asynchronous serial input
//   txd  - serial output, idle high
//
// Optional feature: define UARTFIFO_PARITY_EN to enable parity generation
// and checking (CONTROL b2/b3, STATUS b5). Without it frames are 8N1/8N2.

module uartfifo #(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd38
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] TX_HALF = (FIFO_AW+1)'(DEPTH / 2);

`ifdef UARTFIFO_PARITY_EN
  localparam logic [7:0] CTRL_MASK = 8'h9F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h93;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

  logic [7:0]  ctrl;
  logic [15:0] div_q, presc;
  logic        tick;
  logic        par_en, par_odd, two_stop, loopback;

  logic             wr_en, rd_en, status_wr;
  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  uart_state_t tx_state, tx_next;
  logic [3:0]  tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_par, tx_stop2, tx_last, tx_line;

  uart_state_t rx_state, rx_next;
  logic [3:0]  rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_s1, rx_s2, rx_in, rx_last, rx_half, rx_stop_sample;
  logic        ovr, ferr, perr, ovr_set, ferr_set, perr_set;

  assign two_stop = ctrl[4];
  assign loopback = ctrl[7];
`ifdef UARTFIFO_PARITY_EN
  assign par_en  = ctrl[2];
  assign par_odd = ctrl[3];
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  assign wr_en     = cs & ~rw;
  assign rd_en     = cs & rw;
  assign status_wr = wr_en && (AD == 3'd1);

  assign tx_full  = tx_count[FIFO_AW];
  assign tx_empty = (tx_count == '0);
  assign rx_full  = rx_count[FIFO_AW];
  assign rx_empty = (rx_count == '0);

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign rx_pop  = rd_en && (AD == 3'd0) && !rx_empty;
  assign tx_push = wr_en && (AD == 3'd0) && (!tx_full || tx_pop);
  assign rx_push = rx_stop_sample && (!rx_full || rx_pop);

  // Configuration registers and prescaler; writing DIVH restarts the prescaler on the new divisor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl  <= 8'h00;
      div_q <= DEFAULT_DIV;
      presc <= DEFAULT_DIV;
    end else begin
      if (wr_en && AD == 3'd2) ctrl <= DI & CTRL_MASK;
      if (wr_en && AD == 3'd3) div_q[7:0]  <= DI;
      if (wr_en && AD == 3'd4) div_q[15:8] <= DI;
      if (wr_en && AD == 3'd4) presc <= {DI, div_q[7:0]};
      else if (tick)           presc <= div_q;
      else                     presc <= presc - 16'd1;
    end
  end

  assign tick = (presc == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= DI;
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  // ---------------- Transmitter ----------------
  assign tx_last = tick && (tx_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= ST_IDLE;
    else      tx_state <= tx_next;
  end

  // STOP either repeats once for two stop bits or chains straight into the next START.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      ST_IDLE:   if (tick && !tx_empty) begin tx_next = ST_START; tx_pop = 1'b1; end
      ST_START:  if (tx_last) tx_next = ST_DATA;
      ST_DATA:   if (tx_last && tx_bit == 3'd7) tx_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tx_last) tx_next = ST_STOP;
      ST_STOP: begin
        if (tx_last && !(two_stop && !tx_stop2)) begin
          if (!tx_empty) begin tx_next = ST_START; tx_pop = 1'b1; end
          else           tx_next = ST_IDLE;
        end
      end
      default:   tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= 4'd0; tx_bit <= 3'd0; tx_shift <= 8'h00; tx_par <= 1'b0; tx_stop2 <= 1'b0;
    end else begin
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rp];
        tx_par   <= (^tx_mem[tx_rp]) ^ par_odd;
      end else if (tx_last && tx_state == ST_DATA) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
      end
      if (tick) tx_cnt <= (tx_state == ST_IDLE) ? 4'd0 : tx_cnt + 4'd1;
      if (tx_last && tx_state == ST_DATA) tx_bit <= tx_bit + 3'd1;
      if (tx_last && tx_state == ST_STOP) tx_stop2 <= two_stop && !tx_stop2;
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_shift[0];
      ST_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
  end

  assign txd = loopback ? 1'b1 : tx_line;

  // ---------------- Receiver ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin rx_s1 <= 1'b1; rx_s2 <= 1'b1; end
    else      begin rx_s1 <= rxd;  rx_s2 <= rx_s1; end
  end

  assign rx_in   = loopback ? tx_line : rx_s2;
  assign rx_last = tick && (rx_cnt == 4'd15);
  assign rx_half = tick && (rx_cnt == 4'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= ST_IDLE;
    else      rx_state <= rx_next;
  end

  // A start bit must still be low half a bit later, otherwise it was a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:   if (!rx_in) rx_next = ST_START;
      ST_START:  if (rx_half) rx_next = rx_in ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_last && rx_bit == 3'd7) rx_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_last) rx_next = ST_STOP;
      ST_STOP:   if (rx_last) rx_next = ST_IDLE;
      default:   rx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_sample = (rx_state == ST_STOP) && rx_last;
    ferr_set = rx_stop_sample && !rx_in;
    ovr_set  = rx_stop_sample && rx_full && !rx_pop;
    perr_set = par_en && (rx_state == ST_PARITY) && rx_last &&
               (rx_in != ((^rx_shift) ^ par_odd));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt <= 4'd0; rx_bit <= 3'd0; rx_shift <= 8'h00;
    end else begin
      if (rx_state == ST_IDLE || rx_next != rx_state) rx_cnt <= 4'd0;
      else if (tick)                                  rx_cnt <= rx_cnt + 4'd1;
      if (rx_last && rx_state == ST_DATA) begin
        rx_shift <= {rx_in, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // Sticky error flags: a new detection beats a CPU clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr <= 1'b0; ferr <= 1'b0; perr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(status_wr & DI[3]));
      ferr <= ferr_set | (ferr & ~(status_wr & DI[4]));
      perr <= perr_set | (perr & ~(status_wr & DI[5]));
    end
  end

  assign irq = (ctrl[0] & !rx_empty) | (ctrl[1] & (tx_count <= TX_HALF));

  always_comb begin
    DO = 8'h00;
    case (AD)
      3'd0: DO = rx_empty ? 8'h00 : rx_mem[rx_rp];
      3'd1: DO = {irq, 1'b0, perr, ferr, ovr, tx_empty && (tx_state == ST_IDLE), !tx_full, !rx_empty};
      3'd2: DO = ctrl;
      3'd3: DO = div_q[7:0];
      3'd4: DO = div_q[15:8];
      3'd5: DO = 8'(rx_count);
      3'd6: DO = 8'(tx_count);
      default: DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uartfifo.sv
// tb_uartfifo - directed self-checking bench for uartfifo (FIFO_AW=2, 4-byte FIFOs).
// Bus cycles start on a falling clock edge; outputs are sampled away from the rising edge.

module tb_uartfifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] AD  = 3'd0;
  logic [7:0] DI  = 8'h00;
  logic [7:0] DO;
  logic       rw  = 1'b1;
  logic       cs  = 1'b0;
  logic       irq;
  logic       rxd = 1'b1;
  logic       txd;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rd;
  logic [9:0] frame;

`ifdef UARTFIFO_PARITY_EN
  localparam logic [7:0] CTRL_ALL = 8'h9F;
`else
  localparam logic [7:0] CTRL_ALL = 8'h93;
`endif

  uartfifo #(.FIFO_AW(2), .DEFAULT_DIV(16'd38)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw),
    .cs(cs), .irq(irq), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  // One bus cycle starting at a falling edge; read data is captured mid-cycle.
  task automatic applyStimulus(input logic [2:0] addr, input logic is_read,
                               input logic [7:0] wdata, output logic [7:0] rdata);
    AD = addr; rw = is_read; DI = wdata; cs = 1'b1;
    #1 rdata = DO;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one external frame on rxd at 16 clocks per bit (DIV=0).
  task automatic sendRxFrame(input logic [7:0] data, input logic has_par,
                             input logic par_bit, input logic stop_bit);
    rxd = 1'b0; waitClocks(16);
    for (int i = 0; i < 8; i++) begin rxd = data[i]; waitClocks(16); end
    if (has_par) begin rxd = par_bit; waitClocks(16); end
    rxd = stop_bit; waitClocks(16);
    rxd = 1'b1; waitClocks(24);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting uartfifo bench");
    waitClocks(4);
    rst = 1'b1;
    waitClocks(1);

    // Reset state
    checkOutput("reset_txd", txd, 1'b1);
    checkOutput("reset_irq", irq, 1'b0);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("reset_status", rd, 8'h06);
    applyStimulus(3'd3, 1'b1, 8'h00, rd); checkOutput("reset_divl", rd, 8'h26);
    applyStimulus(3'd4, 1'b1, 8'h00, rd); checkOutput("reset_divh", rd, 8'h00);
    applyStimulus(3'd2, 1'b1, 8'h00, rd); checkOutput("reset_ctrl", rd, 8'h00);

    // CONTROL keeps only implemented bits
    applyStimulus(3'd2, 1'b0, 8'hFF, rd);
    applyStimulus(3'd2, 1'b1, 8'h00, rd); checkOutput("ctrl_readback", rd, CTRL_ALL);
    applyStimulus(3'd2, 1'b0, 8'h00, rd);
    applyStimulus(3'd7, 1'b1, 8'h00, rd); checkOutput("reg7_zero", rd, 8'h00);

    // DIV=0 and transmit 0x55
    applyStimulus(3'd3, 1'b0, 8'h00, rd);
    applyStimulus(3'd4, 1'b0, 8'h00, rd);
    applyStimulus(3'd0, 1'b0, 8'h55, rd);
    waitClocks(1);
    checkOutput("tx_start_first_clock", txd, 1'b0);
    waitClocks(8);
    frame[0] = txd;
    for (int i = 1; i < 10; i++) begin
      waitClocks(16);
      frame[i] = txd;
    end
    checkOutput("tx_frame_55", frame, {1'b1, 8'h55, 1'b0});
    waitClocks(10);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("tx_done_status", rd, 8'h06);

    // Loopback of three bytes
    applyStimulus(3'd2, 1'b0, 8'h80, rd);
    applyStimulus(3'd0, 1'b0, 8'h00, rd);
    applyStimulus(3'd0, 1'b0, 8'hFF, rd);
    applyStimulus(3'd0, 1'b0, 8'hA5, rd);
    waitClocks(20);
    checkOutput("loop_txd_held_high", txd, 1'b1);
    waitClocks(600);
    applyStimulus(3'd5, 1'b1, 8'h00, rd); checkOutput("loop_rxlvl_3", rd, 8'h03);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("loop_byte0", rd, 8'h00);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("loop_byte1", rd, 8'hFF);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("loop_byte2", rd, 8'hA5);
    applyStimulus(3'd5, 1'b1, 8'h00, rd); checkOutput("loop_rxlvl_0", rd, 8'h00);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("empty_data_read", rd, 8'h00);

    // Overrun: five bytes into a four-byte RX FIFO
    applyStimulus(3'd0, 1'b0, 8'h11, rd);
    applyStimulus(3'd0, 1'b0, 8'h22, rd);
    applyStimulus(3'd0, 1'b0, 8'h33, rd);
    applyStimulus(3'd0, 1'b0, 8'h44, rd);
    applyStimulus(3'd0, 1'b0, 8'h55, rd);
    waitClocks(900);
    applyStimulus(3'd5, 1'b1, 8'h00, rd); checkOutput("ovr_rxlvl_4", rd, 8'h04);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("ovr_status_set", rd, 8'h0F);
    applyStimulus(3'd1, 1'b0, 8'h08, rd);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("ovr_status_clr", rd, 8'h07);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("ovr_byte0", rd, 8'h11);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("ovr_byte1", rd, 8'h22);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("ovr_byte2", rd, 8'h33);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("ovr_byte3", rd, 8'h44);
    applyStimulus(3'd5, 1'b1, 8'h00, rd); checkOutput("ovr_rxlvl_0", rd, 8'h00);

    // External frames: framing error, then a clean frame
    applyStimulus(3'd2, 1'b0, 8'h00, rd);
    sendRxFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd5, 1'b1, 8'h00, rd); checkOutput("ferr_rxlvl_1", rd, 8'h01);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("ferr_status", rd, 8'h17);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("ferr_byte", rd, 8'h3C);
    applyStimulus(3'd1, 1'b0, 8'h10, rd);
    sendRxFrame(8'hC3, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("rx_byte_c3", rd, 8'hC3);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("rx_clean_status", rd, 8'h06);

`ifdef UARTFIFO_PARITY_EN
    // Even parity with a wrong parity bit
    applyStimulus(3'd2, 1'b0, 8'h04, rd);
    sendRxFrame(8'h3C, 1'b1, 1'b1, 1'b1);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("perr_status", rd, 8'h27);
    applyStimulus(3'd0, 1'b1, 8'h00, rd); checkOutput("perr_byte", rd, 8'h3C);
    applyStimulus(3'd1, 1'b0, 8'h20, rd);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("perr_clr", rd, 8'h06);
`endif

    // TX level interrupt
    applyStimulus(3'd2, 1'b0, 8'h02, rd);
    checkOutput("irq_tx_empty", irq, 1'b1);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("irq_status_b7", rd, 8'h86);
    applyStimulus(3'd0, 1'b0, 8'h00, rd);
    applyStimulus(3'd0, 1'b0, 8'h00, rd);
    applyStimulus(3'd0, 1'b0, 8'h00, rd);
    applyStimulus(3'd0, 1'b0, 8'h00, rd);
    applyStimulus(3'd6, 1'b1, 8'h00, rd); checkOutput("irq_txlvl_3", rd, 8'h03);
    checkOutput("irq_low_above_half", irq, 1'b0);
    waitClocks(100);
    checkOutput("irq_still_low", irq, 1'b0);
    waitClocks(100);
    checkOutput("irq_high_after_drain", irq, 1'b1);
    applyStimulus(3'd6, 1'b1, 8'h00, rd); checkOutput("irq_txlvl_2", rd, 8'h02);
    checkOutput("mid_frame_txd_low", txd, 1'b0);

    // Reset in the middle of a frame
    rst = 1'b0;
    #1;
    checkOutput("midreset_txd", txd, 1'b1);
    checkOutput("midreset_irq", irq, 1'b0);
    waitClocks(2);
    rst = 1'b1;
    waitClocks(1);
    applyStimulus(3'd1, 1'b1, 8'h00, rd); checkOutput("midreset_status", rd, 8'h06);
    applyStimulus(3'd3, 1'b1, 8'h00, rd); checkOutput("midreset_divl", rd, 8'h26);
    applyStimulus(3'd4, 1'b1, 8'h00, rd); checkOutput("midreset_divh", rd, 8'h00);
    applyStimulus(3'd6, 1'b1, 8'h00, rd); checkOutput("midreset_txlvl", rd, 8'h00);
    applyStimulus(3'd2, 1'b1, 8'h00, rd); checkOutput("midreset_ctrl", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
